// File: rtl/arm7tdmi_pkg.sv
// arm7tdmi_pkg: shared types for the arm7tdmi memory-side blocks.
// Holds arbiter state/owner enums and fetch access constants.
package arm7tdmi_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY_I,
    ARB_BUSY_D,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH,
    OWN_DATA
  } arb_owner_t;

  localparam logic [3:0]  FETCH_BE    = 4'hF;
  localparam logic [31:0] FETCH_WDATA = 32'h0;

  function automatic arb_owner_t busy_owner(input arb_state_t s);
    return (s == ARB_BUSY_D) ? OWN_DATA : OWN_FETCH;
  endfunction

endpackage

// File: rtl/arm7tdmi_arb_starve_ctr.sv
// arm7tdmi_arb_starve_ctr: saturating up-counter with clear.
// Used for fetch starvation tracking and the BUSY wait timer.
module arm7tdmi_arb_starve_ctr #(
  parameter int           W   = 4,
  parameter logic [W-1:0] MAX = W'(4)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_at_max = (r_cnt == MAX);

endmodule

// File: rtl/arm7tdmi_mem_arbiter.sv
// arm7tdmi_mem_arbiter: shares the core memory port between fetch and data.
// Build option MEM_ARB_TIMEOUT_EN aborts stalled accesses with bus_err.
import arm7tdmi_pkg::*;

module arm7tdmi_mem_arbiter #(
  parameter int MAX_STARVE = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        bus_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic        mem_re,
  output logic [3:0]  mem_be,
  input  logic        mem_ready
);

  arb_state_t  r_state;
  arb_state_t  w_state_n;
  logic [31:0] r_mem_addr;
  logic [31:0] w_mem_addr_n;
  logic [31:0] r_mem_wdata;
  logic [31:0] w_mem_wdata_n;
  logic [3:0]  r_mem_be;
  logic [3:0]  w_mem_be_n;
  logic        r_mem_we;
  logic        w_mem_we_n;
  logic        r_mem_re;
  logic        w_mem_re_n;
  logic [31:0] r_if_rdata;
  logic [31:0] w_if_rdata_n;
  logic [31:0] r_d_rdata;
  logic [31:0] w_d_rdata_n;
  logic        r_if_ack;
  logic        w_if_ack_n;
  logic        r_d_ack;
  logic        w_d_ack_n;
  logic        r_bus_err;
  logic        w_bus_err_n;

  logic        w_st_inc;
  logic        w_st_clr;
  logic        w_st_max;
  logic        w_d_win;
  logic        w_timeout;
  arb_owner_t  w_owner;

  arm7tdmi_arb_starve_ctr #(
    .W   (4),
    .MAX (4'(MAX_STARVE))
  ) u_starve_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_inc    (w_st_inc),
    .i_clr    (w_st_clr),
    .o_at_max (w_st_max)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;

  logic w_busy;
  logic w_wait_max;

  assign w_busy = (r_state == ARB_BUSY_I) ||
                  (r_state == ARB_BUSY_D);

  // Held clear outside BUSY so every access starts at zero.
  arm7tdmi_arb_starve_ctr #(
    .W   (TW),
    .MAX (TW'(TIMEOUT - 1))
  ) u_wait_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_inc    (w_busy && !mem_ready),
    .i_clr    (!w_busy),
    .o_at_max (w_wait_max)
  );

  assign w_timeout = w_busy && w_wait_max && !mem_ready;
`else
  assign w_timeout = 1'b0;
`endif

  assign w_d_win = d_req && !(if_req && w_st_max);
  assign w_owner = busy_owner(r_state);

  always_comb begin
    w_state_n     = r_state;
    w_mem_addr_n  = r_mem_addr;
    w_mem_wdata_n = r_mem_wdata;
    w_mem_be_n    = r_mem_be;
    w_mem_we_n    = r_mem_we;
    w_mem_re_n    = r_mem_re;
    w_if_rdata_n  = '0;
    w_d_rdata_n   = '0;
    w_if_ack_n    = 1'b0;
    w_d_ack_n     = 1'b0;
    w_bus_err_n   = 1'b0;
    w_st_inc      = 1'b0;
    w_st_clr      = 1'b0;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_d_win) begin
          w_state_n     = ARB_BUSY_D;
          w_mem_addr_n  = d_addr;
          w_mem_wdata_n = d_wdata;
          w_mem_be_n    = d_be;
          w_mem_we_n    = d_we;
          w_mem_re_n    = !d_we;
          w_st_inc      = if_req;
        end else if (if_req) begin
          w_state_n     = ARB_BUSY_I;
          w_mem_addr_n  = if_addr;
          w_mem_wdata_n = FETCH_WDATA;
          w_mem_be_n    = FETCH_BE;
          w_mem_we_n    = 1'b0;
          w_mem_re_n    = 1'b1;
          w_st_clr      = 1'b1;
        end
      end
      ARB_BUSY_I,
      ARB_BUSY_D: begin
        // A same-cycle mem_ready beats the timeout abort.
        if (mem_ready || w_timeout) begin
          w_state_n   = ARB_RESP;
          w_mem_we_n  = 1'b0;
          w_mem_re_n  = 1'b0;
          w_bus_err_n = !mem_ready;
          if (w_owner == OWN_DATA) begin
            w_d_ack_n = 1'b1;
            if (mem_ready && !r_mem_we) begin
              w_d_rdata_n = mem_rdata;
            end
          end else begin
            w_if_ack_n = 1'b1;
            if (mem_ready) begin
              w_if_rdata_n = mem_rdata;
            end
          end
        end
      end
      ARB_RESP: begin
        w_state_n = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ARB_IDLE;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_ack    <= 1'b0;
      r_d_ack     <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_mem_addr  <= w_mem_addr_n;
      r_mem_wdata <= w_mem_wdata_n;
      r_mem_be    <= w_mem_be_n;
      r_mem_we    <= w_mem_we_n;
      r_mem_re    <= w_mem_re_n;
      r_if_rdata  <= w_if_rdata_n;
      r_d_rdata   <= w_d_rdata_n;
      r_if_ack    <= w_if_ack_n;
      r_d_ack     <= w_d_ack_n;
      r_bus_err   <= w_bus_err_n;
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;
  assign mem_we    = r_mem_we;
  assign mem_re    = r_mem_re;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign if_ack    = r_if_ack;
  assign d_ack     = r_d_ack;
  assign bus_err   = r_bus_err;

endmodule
